// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sample-feeder controller: FSM encoding,
// register map addresses and register bit positions.
package i2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_READY   = 3'd2,
    ST_POP_L   = 3'd3,
    ST_POP_R   = 3'd4,
    ST_CAP     = 3'd5
  } i2s_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CLKDIV = 2'd2;
  localparam logic [1:0] ADDR_DATA   = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MUTE   = 1;
  localparam int CTRL_PF_LSB = 8;
  localparam int PF_W        = 6;

  localparam int STAT_UNDERRUN = 3;
  localparam int STAT_OVERFLOW = 4;
  localparam int STAT_FULL     = 5;
  localparam int STAT_EMPTY    = 6;
  localparam int STAT_USED_LSB = 8;

endpackage

// File: rtl/i2s_ctrl_if.sv
// Avalon-MM register slave bus for i2s_ctrl.
interface i2s_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata);
endinterface

// File: rtl/i2s_ctrl_regs.sv
// Register file: CTRL/STATUS/CLKDIV/DATA, sticky error flags and the
// registered FIFO push generated by DATA writes.
module i2s_ctrl_regs
  import i2s_pkg::*;
#(
  parameter int DW  = 16,
  parameter int UW  = 6,
  parameter int CDW = 8
) (
  input  logic             clk,
  input  logic             reset,
  i2s_ctrl_if.slave        avs,
  input  i2s_state_e       state,
  input  logic             underrun_set,
  input  logic             fifo_full,
  input  logic [UW-1:0]    fifo_used,
  output logic             en,
  output logic             mute,
  output logic [PF_W-1:0]  prefill,
  output logic [CDW-1:0]   clk_div,
  output logic             fifo_write,
  output logic [DW-1:0]    fifo_wdata
);

  logic            en_q, en_d, mute_q, mute_d;
  logic [PF_W-1:0] pf_q, pf_d;
  logic [CDW-1:0]  div_q, div_d;
  logic            urun_q, urun_d, ovf_q, ovf_d;
  logic            fw_q, fw_d;
  logic [DW-1:0]   fwd_q, fwd_d;
  logic [31:0]     rdata_q, rdata_d, rd_mux, wd;
  logic            wr_ctrl, wr_status, wr_clkdiv, wr_data;

  always_comb begin
    wd        = avs.avs_writedata;
    wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    wr_status = avs.avs_write && (avs.avs_address == ADDR_STATUS);
    wr_clkdiv = avs.avs_write && (avs.avs_address == ADDR_CLKDIV);
    wr_data   = avs.avs_write && (avs.avs_address == ADDR_DATA);

    en_d   = en_q;
    mute_d = mute_q;
    pf_d   = pf_q;
    div_d  = div_q;
    if (wr_ctrl) begin
      en_d   = wd[CTRL_EN];
      mute_d = wd[CTRL_MUTE];
      pf_d   = wd[CTRL_PF_LSB +: PF_W];
    end
    if (wr_clkdiv) div_d = wd[CDW-1:0];

    fw_d  = wr_data && !fifo_full;
    fwd_d = wr_data ? wd[DW-1:0] : fwd_q;

    // Write-1-to-clear, but a same-cycle set event takes priority.
    urun_d = (urun_q && !(wr_status && wd[STAT_UNDERRUN])) || underrun_set;
    ovf_d  = (ovf_q  && !(wr_status && wd[STAT_OVERFLOW])) || (wr_data && fifo_full);

    rd_mux = '0;
    case (avs.avs_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN]              = en_q;
        rd_mux[CTRL_MUTE]            = mute_q;
        rd_mux[CTRL_PF_LSB +: PF_W]  = pf_q;
      end
      ADDR_STATUS: begin
        rd_mux[2:0]                  = 3'(state);
        rd_mux[STAT_UNDERRUN]        = urun_q;
        rd_mux[STAT_OVERFLOW]        = ovf_q;
        rd_mux[STAT_FULL]            = fifo_full;
        rd_mux[STAT_EMPTY]           = (fifo_used == '0);
        rd_mux[STAT_USED_LSB +: 8]   = 8'(fifo_used);
      end
      ADDR_CLKDIV: rd_mux[CDW-1:0]   = div_q;
      default:     rd_mux            = '0;
    endcase
    rdata_d = avs.avs_read ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      mute_q  <= 1'b0;
      pf_q    <= '0;
      div_q   <= '0;
      urun_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fw_q    <= 1'b0;
      fwd_q   <= '0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      mute_q  <= mute_d;
      pf_q    <= pf_d;
      div_q   <= div_d;
      urun_q  <= urun_d;
      ovf_q   <= ovf_d;
      fw_q    <= fw_d;
      fwd_q   <= fwd_d;
      rdata_q <= rdata_d;
    end
  end

  assign en               = en_q;
  assign mute             = mute_q;
  assign prefill          = pf_q;
  assign clk_div          = div_q;
  assign fifo_write       = fw_q;
  assign fifo_wdata       = fwd_q;
  assign avs.avs_readdata = rdata_q;

endmodule

// File: rtl/i2s_ctrl.sv
// I2S sample feeder: pops L/R word pairs from the FIFO on each frame request
// and presents them as a registered pair with a frame_valid strobe.
module i2s_ctrl
  import i2s_pkg::*;
#(
  parameter int DW  = 16,
  parameter int UW  = 6,
  parameter int CDW = 8
) (
  input  logic           clk,
  input  logic           reset,
  i2s_ctrl_if.slave      avs,
  output logic           fifo_write,
  output logic [DW-1:0]  fifo_wdata,
  input  logic           fifo_full,
  output logic           fifo_read,
  input  logic [DW-1:0]  fifo_rdata,
  input  logic [UW-1:0]  fifo_used,
  input  logic           frame_req,
  output logic [DW-1:0]  data_left,
  output logic [DW-1:0]  data_right,
  output logic           frame_valid,
  output logic           i2s_en,
  output logic [CDW-1:0] clk_div
);

  i2s_state_e      state_q, state_d;
  logic            pend_q, pend_d;
  logic [DW-1:0]   stage_q, stage_d, left_q, left_d, right_q, right_d;
  logic            fv_q, fv_d;
  logic            en, mute, urun_set, avail2, prefill_ok;
  logic [PF_W-1:0] prefill;
  logic [DW-1:0]   rword;

  i2s_ctrl_regs #(.DW(DW), .UW(UW), .CDW(CDW)) u_regs (
    .clk          (clk),
    .reset        (reset),
    .avs          (avs),
    .state        (state_q),
    .underrun_set (urun_set),
    .fifo_full    (fifo_full),
    .fifo_used    (fifo_used),
    .en           (en),
    .mute         (mute),
    .prefill      (prefill),
    .clk_div      (clk_div),
    .fifo_write   (fifo_write),
    .fifo_wdata   (fifo_wdata)
  );

  // Two words must be present so neither pop can hit an empty FIFO.
  assign avail2     = 32'(fifo_used) >= 32'd2;
  assign prefill_ok = avail2 && (32'(fifo_used) >= 32'(prefill));
  assign rword      = mute ? '0 : fifo_rdata;

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    stage_d  = stage_q;
    left_d   = left_q;
    right_d  = right_q;
    fv_d     = 1'b0;
    urun_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (en) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        pend_d = 1'b0;
        if (!en)             state_d = ST_IDLE;
        else if (prefill_ok) state_d = ST_READY;
      end
      ST_READY: begin
        if (!en) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end else if (frame_req || pend_q) begin
          // A fresh request arriving while the held one is consumed stays held.
          pend_d = pend_q && frame_req;
          if (avail2) begin
            state_d = ST_POP_L;
          end else begin
            left_d   = '0;
            right_d  = '0;
            fv_d     = 1'b1;
            urun_set = 1'b1;
          end
        end
      end
      ST_POP_L, ST_POP_R, ST_CAP: begin
        if (frame_req) begin
          if (pend_q) urun_set = 1'b1;
          else        pend_d   = 1'b1;
        end
        if (state_q == ST_POP_L) state_d = ST_POP_R;
        if (state_q == ST_POP_R) begin
          state_d = ST_CAP;
          stage_d = rword;
        end
        if (state_q == ST_CAP) begin
          left_d  = stage_q;
          right_d = rword;
          fv_d    = 1'b1;
          state_d = en ? ST_READY : ST_IDLE;
          if (!en) pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      stage_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      stage_q <= stage_d;
      left_q  <= left_d;
      right_q <= right_d;
      fv_q    <= fv_d;
    end
  end

  assign fifo_read   = (state_q == ST_POP_L) || (state_q == ST_POP_R);
  assign i2s_en      = (state_q == ST_READY) || (state_q == ST_POP_L) ||
                       (state_q == ST_POP_R) || (state_q == ST_CAP);
  assign data_left   = left_q;
  assign data_right  = right_q;
  assign frame_valid = fv_q;

endmodule

// File: doc/i2s_ctrl.md
I2S_CTRL -- requirements
Module: i2s_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16: sample width per channel, which is also the FIFO word width.
REQ-002 SHALL have parameter UW, default 6: width of the FIFO fill count.
REQ-003 SHALL have parameter CDW, default 8: width of the clock-divider field.
REQ-004 SHALL have port clk, input, 1: the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port avs_address, input, 2: Avalon-MM word address (0 CTRL, 1 STATUS, 2 CLKDIV, 3 DATA).
REQ-007 SHALL have ports avs_read (input, 1) and avs_readdata (output, 32): register read, returning data with 1-cycle latency.
REQ-008 SHALL have ports avs_write (input, 1) and avs_writedata (input, 32): register write; there is no waitrequest.
REQ-009 SHALL have ports fifo_write (output, 1) and fifo_wdata (output, DW): FIFO push.
REQ-010 SHALL have port fifo_full, input, 1: FIFO full flag.
REQ-011 SHALL have ports fifo_read (output, 1) and fifo_rdata (input, DW): FIFO pop; rdata is valid the cycle after read.
REQ-012 SHALL have port fifo_used, input, UW: number of words in the FIFO.
REQ-013 SHALL have port frame_req, input, 1: single-cycle pulse, already synchronous to clk, requesting the next L/R pair.
REQ-014 SHALL have ports data_left and data_right, output, DW each: registered sample pair to the I2S core.
REQ-015 SHALL have port frame_valid, output, 1: 1-cycle pulse when data_left/data_right update.
REQ-016 SHALL have ports i2s_en (output, 1) and clk_div (output, CDW): core enable and divider value.

Function
REQ-017 Registers SHALL be:
- CTRL: bit0 EN, bit1 MUTE, bits[13:8] PREFILL threshold.
- STATUS: bits[2:0] state, bit3 underrun, bit4 overflow, bit5 full, bit6 empty, bits[15:8] fifo_used (zero-extended).
- CLKDIV: bits[CDW-1:0].
- DATA: write-only; reads return 0.
REQ-018 A DATA write SHALL assert fifo_write for exactly 1 cycle with fifo_wdata = writedata[DW-1:0], in the cycle after the write strobe.
REQ-019 A DATA write while fifo_full SHALL NOT push; it SHALL set sticky overflow instead.
REQ-020 Writing 1 to STATUS bit3 or bit4 SHALL clear that bit; a set event in the same cycle SHALL win over the clear.
REQ-021 The FSM SHALL have states IDLE, PREFILL, READY, POP_L, POP_R, CAP.
REQ-022 IDLE -> PREFILL when EN=1; PREFILL -> READY when fifo_used >= PREFILL and fifo_used >= 2.
REQ-023 On frame_req in READY with fifo_used >= 2, the FSM SHALL step POP_L -> POP_R -> CAP -> READY, one cycle each.
- fifo_read is high in POP_L and POP_R.
- The left word is captured at the end of POP_R, the right word at the end of CAP.
REQ-024 Outputs SHALL update, and frame_valid pulse, exactly 4 cycles after the frame_req edge.
REQ-025 frame_req in READY with fifo_used < 2 (underrun) SHALL load zeros on both channels, pulse frame_valid 1 cycle later, set sticky underrun, and pop nothing.
REQ-026 A frame_req arriving in POP_L, POP_R or CAP SHALL be held in a single pending flag and serviced on return to READY; a second request while one is pending SHALL be dropped and SHALL set underrun.
REQ-027 MUTE=1 SHALL still pop the FIFO but drive zero data.
REQ-028 EN cleared mid-sequence SHALL complete the sequence through CAP, then go to IDLE; EN cleared in PREFILL or READY SHALL go to IDLE next cycle. Any pending request SHALL be discarded.
REQ-029 i2s_en SHALL be 1 only in READY, POP_L, POP_R and CAP.
REQ-030 clk_div SHALL mirror CLKDIV.
REQ-031 fifo_read SHALL never be asserted while fifo_empty holds (guaranteed by the fifo_used >= 2 check).

Reset
REQ-032 On reset, the FSM SHALL go to IDLE and all registers, sticky bits and the pending flag SHALL be 0. All outputs SHALL be 0, including avs_readdata, data_left, data_right, frame_valid, fifo_read, fifo_write, i2s_en and clk_div.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no further FIFO access on the following cycle.

Structure
REQ-034 A shared package i2s_pkg SHALL hold the state encoding, the register address constants and the bit-position constants.
REQ-035 The register file SHALL be one sub-module, i2s_ctrl_regs; the FSM and datapath SHALL remain in i2s_ctrl.

Verification
REQ-036 Write 0xA1, 0xB2, 0xC3, 0xD4 to DATA; write CTRL EN=1, PREFILL=4; pulse frame_req twice -> outputs L=0xA1/R=0xB2, then L=0xC3/R=0xD4, each 4 cycles after its request.
REQ-037 With EN=1 and an empty FIFO in READY, pulse frame_req -> zeros on both channels, STATUS bit3 set, fifo_read never high; write 0x8 to STATUS -> bit3 cleared.
REQ-038 Hold fifo_full=1 and write DATA -> no fifo_write, STATUS bit4 set.
REQ-039 Pulse frame_req during POP_R with 4 words queued -> second pair delivered at CAP+1+4 cycles, no underrun.
REQ-040 Clear EN during POP_L -> POP_R and CAP complete, then IDLE, i2s_en=0; assert reset during POP_R -> all outputs 0 next cycle.
